// File: rtl/pwm_breath_multi.sv
`default_nettype none
//==============================================================================
// Module      : pwm_breath_multi
// Description : Multi-channel breathing-LED PWM generator sharing one PWM
//               counter and one ramp prescaler across all channels.
// Revision    : 1.0 - initial release
//==============================================================================
module pwm_breath_multi #(
    parameter int CHANNELS = 4,
    parameter int PWM_W    = 8,
    parameter int PRESC_W  = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PRESC_W-1:0]  presc_max,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_end
);

    localparam logic [1:0]       c_MODE_OFF     = 2'b00;
    localparam logic [1:0]       c_MODE_ON      = 2'b01;
    localparam logic [1:0]       c_MODE_BREATHE = 2'b10;
    localparam logic [1:0]       c_MODE_FIXED   = 2'b11;
    localparam logic [PWM_W-1:0] c_LEVEL_MAX    = '1;

    logic [PWM_W-1:0]    r_cnt;
    logic [PRESC_W-1:0]  r_presc;
    logic                r_tick_pend;
    logic                r_period_end;
    logic [CHANNELS-1:0] r_pwm;
    logic [1:0]          r_mode  [CHANNELS];
    logic [PWM_W-1:0]    r_level [CHANNELS];
    logic                r_dir   [CHANNELS];

    logic w_boundary;
    logic w_update;

    // Reset levels spread the channels evenly across the duty range.
    function automatic logic [PWM_W-1:0] f_reset_level(input int c);
        longint v;
        v = (longint'(c) << PWM_W) / longint'(CHANNELS);
        return PWM_W'(v);
    endfunction

    assign w_boundary = (r_cnt == c_LEVEL_MAX);
    assign w_update   = w_boundary & r_tick_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_presc      <= '0;
            r_tick_pend  <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_cnt        <= r_cnt + PWM_W'(1);
            r_period_end <= w_boundary;
            if (r_presc == presc_max) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            // A tick landing on the update edge must not be lost.
            if (r_presc == presc_max) begin
                r_tick_pend <= 1'b1;
            end else if (w_update) begin
                r_tick_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_mode[c]  <= c_MODE_BREATHE;
                r_level[c] <= f_reset_level(c);
                r_dir[c]   <= 1'b1;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_we && (cfg_ch == CH_W'(c))) begin
                    r_mode[c] <= cfg_mode;
                    if ((cfg_mode == c_MODE_FIXED) || (cfg_mode == c_MODE_BREATHE)) begin
                        r_level[c] <= cfg_duty;
                    end
                    if (cfg_mode == c_MODE_BREATHE) begin
                        r_dir[c] <= 1'b1;
                    end
                end else if (w_update && (r_mode[c] == c_MODE_BREATHE)) begin
                    if (r_dir[c]) begin
                        if (r_level[c] == c_LEVEL_MAX) begin
                            r_dir[c]   <= 1'b0;
                            r_level[c] <= c_LEVEL_MAX - PWM_W'(1);
                        end else begin
                            r_level[c] <= r_level[c] + PWM_W'(1);
                        end
                    end else begin
                        if (r_level[c] == '0) begin
                            r_dir[c]   <= 1'b1;
                            r_level[c] <= PWM_W'(1);
                        end else begin
                            r_level[c] <= r_level[c] - PWM_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                case (r_mode[c])
                    c_MODE_OFF: r_pwm[c] <= 1'b0;
                    c_MODE_ON:  r_pwm[c] <= 1'b1;
                    default:    r_pwm[c] <= (r_cnt < r_level[c]);
                endcase
            end
        end
    end

    assign pwm        = r_pwm;
    assign period_end = r_period_end;

endmodule
`default_nettype wire

// File: tb/tb_pwm_breath_multi.sv
`default_nettype none
//==============================================================================
// Module      : tb_pwm_breath_multi
// Description : Scoreboard bench; per-period high counts checked per channel.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pwm_breath_multi;

    logic        clk;
    logic        rst;
    logic [15:0] presc_max;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_duty;
    logic [3:0]  pwm;
    logic        period_end;

    logic [15:0] s_presc_max;
    logic        s_cfg_we;
    logic [1:0]  s_cfg_ch;
    logic [1:0]  s_cfg_mode;
    logic [2:0]  s_cfg_duty;
    logic [2:0]  s_pwm;
    logic        s_period_end;

    int checks   = 0;
    int failures = 0;
    int tb_cyc;

    typedef struct packed {
        int              id;
        logic [3:0][8:0] cnt;
    } exp_t;

    exp_t q_main  [$];
    exp_t q_small [$];

    pwm_breath_multi #(.CHANNELS(4), .PWM_W(8), .PRESC_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .presc_max  (presc_max),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .pwm        (pwm),
        .period_end (period_end)
    );

    pwm_breath_multi #(.CHANNELS(3), .PWM_W(3), .PRESC_W(16)) u_small (
        .clk        (clk),
        .rst        (rst),
        .presc_max  (s_presc_max),
        .cfg_we     (s_cfg_we),
        .cfg_ch     (s_cfg_ch),
        .cfg_mode   (s_cfg_mode),
        .cfg_duty   (s_cfg_duty),
        .pwm        (s_pwm),
        .period_end (s_period_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= 0;
        else      tb_cyc <= tb_cyc + 1;
    end

    // Triangle wave starting upward from 'start', after n ramp updates.
    function automatic int f_tri(input int start, input int n, input int maxv);
        int p;
        p = (start + n) % (2 * maxv);
        return (p <= maxv) ? p : (2 * maxv - p);
    endfunction

    task automatic push_main(input int id, input int a, input int b, input int c, input int d);
        exp_t e;
        e.id = id;
        e.cnt[0] = 9'(a);
        e.cnt[1] = 9'(b);
        e.cnt[2] = 9'(c);
        e.cnt[3] = 9'(d);
        q_main.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        int g;
        g = 0;
        while (tb_cyc != target && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if (tb_cyc != target) check("wait_cyc_timeout", tb_cyc, target);
        #1;
    endtask

    task automatic write_at(input int target, input int ch, input int mode, input int duty);
        wait_cyc(target);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = 8'(duty);
        @(negedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    // Main monitor: accumulate high clocks per channel across one period.
    int m_acc [4];
    int m_cyc;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int c = 0; c < 4; c++) m_acc[c] = 0;
            m_cyc = 0;
        end else begin
            m_cyc++;
            for (int c = 0; c < 4; c++) m_acc[c] += int'(pwm[c]);
            if (period_end) begin
                check("main_period_len", m_cyc, 256);
                if (q_main.size() == 0) begin
                    check("main_unexpected_period", 1, 0);
                end else begin
                    e = q_main.pop_front();
                    for (int c = 0; c < 4; c++) begin
                        checks++;
                        if (m_acc[c] != int'(e.cnt[c])) begin
                            failures++;
                            $display("FAIL main_high_count w%0d ch%0d actual=%0d expected=%0d",
                                     e.id, c, m_acc[c], e.cnt[c]);
                        end
                    end
                end
                for (int c = 0; c < 4; c++) m_acc[c] = 0;
                m_cyc = 0;
            end else if (m_cyc == 257) begin
                check("main_period_end_missing", m_cyc, 256);
            end
        end
    end

    int s_acc [3];
    int s_cyc;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int c = 0; c < 3; c++) s_acc[c] = 0;
            s_cyc = 0;
        end else begin
            s_cyc++;
            for (int c = 0; c < 3; c++) s_acc[c] += int'(s_pwm[c]);
            if (s_period_end) begin
                if (q_small.size() != 0) begin
                    check("small_period_len", s_cyc, 8);
                    e = q_small.pop_front();
                    for (int c = 0; c < 3; c++) begin
                        checks++;
                        if (s_acc[c] != int'(e.cnt[c])) begin
                            failures++;
                            $display("FAIL small_high_count w%0d ch%0d actual=%0d expected=%0d",
                                     e.id, c, s_acc[c], e.cnt[c]);
                        end
                    end
                end
                for (int c = 0; c < 3; c++) s_acc[c] = 0;
                s_cyc = 0;
            end
        end
    end

    // Small instance: tick every 16 clocks, 8-clock period, so the level
    // advances on alternate periods starting at period 3.
    initial begin
        exp_t e;
        int   u;
        s_presc_max = 16'd15;
        s_cfg_we    = 1'b0;
        s_cfg_ch    = 2'd0;
        s_cfg_mode  = 2'd0;
        s_cfg_duty  = 3'd0;
        for (int w = 0; w < 40; w++) begin
            u = (w == 0) ? 0 : (w - 1) / 2;
            e.id     = w;
            e.cnt[0] = 9'(f_tri(0, u, 7));
            e.cnt[1] = 9'(f_tri(2, u, 7));
            e.cnt[2] = 9'(f_tri(5, u, 7));
            e.cnt[3] = 9'd0;
            q_small.push_back(e);
        end
        @(posedge rst);
        while (tb_cyc != 8 * 10 + 3) @(negedge clk);
        #1;
        s_cfg_we   = 1'b1;
        s_cfg_ch   = 2'd3;
        s_cfg_mode = 2'b11;
        s_cfg_duty = 3'd0;
        @(negedge clk);
        #1;
        s_cfg_we   = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=%0d expected=done", tb_cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        presc_max = 16'd0;
        cfg_we    = 1'b0;
        cfg_ch    = 2'd0;
        cfg_mode  = 2'd0;
        cfg_duty  = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_period_end", int'(period_end), 0);
        check("reset_small_pwm", int'(s_pwm), 0);

        for (int n = 0; n < 70; n++)
            push_main(n, f_tri(0, n, 255), f_tri(64, n, 255), f_tri(128, n, 255), f_tri(192, n, 255));
        push_main(70, 70, 134, 101, 151);
        push_main(71, 71, 135, 10, 0);
        push_main(72, 72, 136, 10, 205);
        push_main(73, 73, 137, 10, 256);
        push_main(74, 20, 138, 10, 256);
        push_main(75, 21, 139, 10, 256);
        push_main(76, 22, 140, 10, 100);
        push_main(77, 23, 141, 10, 101);
        #1 rst = 1'b1;

        write_at(256 * 70 + 100, 2, 3, 10);
        write_at(256 * 70 + 150, 3, 0, 99);
        write_at(256 * 72 + 50,  3, 1, 0);
        write_at(256 * 73 + 255, 0, 2, 20);
        write_at(256 * 75 + 255, 3, 2, 100);

        wait_cyc(256 * 78 + 100);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_pwm", int'(pwm), 0);
            check("midreset_period_end", int'(period_end), 0);
        end
        check("midreset_leftover", q_main.size(), 0);
        for (int n = 0; n < 3; n++)
            push_main(100 + n, n, 64 + n, 128 + n, 192 + n);
        #1 rst = 1'b1;

        wait_cyc(256 * 3 + 2);
        check("main_queue_drained", q_main.size(), 0);
        check("small_queue_drained", q_small.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
